// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, flag struct and flag bit positions.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SHL1  = 4'd6,
    OP_SHR1  = 4'd7,
    OP_SLL   = 4'd8,
    OP_SRL   = 4'd9,
    OP_SRA   = 4'd10,
    OP_SLT   = 4'd11,
    OP_SLTU  = 4'd12,
    OP_PASSB = 4'd13,
    OP_MUL   = 4'd14,
    OP_MULHU = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } alu_flags_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: (a, b, op) -> (result, flags, illegal).
// Ops 14/15 (MUL/MULHU) exist only when ALU_PIPE_MUL_EN is defined; otherwise they are reserved.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  diff;
  logic [SW-1:0]   sh;
  logic            signed_lt;

`ifdef ALU_PIPE_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign sh        = b[SW-1:0];
  assign signed_lt = $signed(a) < $signed(b);

  always_comb begin
    result  = '0;
    flags   = '0;
    illegal = 1'b0;
    case (alu_op_e'(op))
      OP_ADD: begin
        result  = sum[WIDTH-1:0];
        flags.c = sum[WIDTH];
        flags.v = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      // diff[WIDTH] is the borrow, i.e. A < B unsigned
      OP_SUB: begin
        result  = diff[WIDTH-1:0];
        flags.c = diff[WIDTH];
        flags.v = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOT:   result = ~a;
      OP_SHL1: begin
        result  = {a[WIDTH-2:0], 1'b0};
        flags.c = a[WIDTH-1];
      end
      OP_SHR1: begin
        result  = {1'b0, a[WIDTH-1:1]};
        flags.c = a[0];
      end
      OP_SLL:   result = a << sh;
      OP_SRL:   result = a >> sh;
      OP_SRA:   result = $signed(a) >>> sh;
      OP_SLT:   result = {{(WIDTH-1){1'b0}}, signed_lt};
      OP_SLTU:  result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_PASSB: result = b;
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: begin
        result  = prod[WIDTH-1:0];
        flags.c = |prod[2*WIDTH-1:WIDTH];
      end
      OP_MULHU: result = prod[2*WIDTH-1:WIDTH];
`endif
      default: begin
        result  = '0;
        illegal = 1'b1;
      end
    endcase
    flags.n = result[WIDTH-1];
    flags.z = (result == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with a PIPE_STAGES-deep result pipeline that stalls as a whole on backpressure.
// Define ALU_PIPE_MUL_EN to enable the MUL/MULHU opcodes in the datapath.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_flags,
  output logic             out_illegal
);

  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;
  logic             core_illegal;
  logic             adv;

  logic [WIDTH-1:0] st_data    [PIPE_STAGES];
  alu_flags_t       st_flags   [PIPE_STAGES];
  logic             st_illegal [PIPE_STAGES];
  logic             st_valid   [PIPE_STAGES];

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .a       (in_a),
    .b       (in_b),
    .op      (in_op),
    .result  (core_result),
    .flags   (core_flags),
    .illegal (core_illegal)
  );

  // Every stage moves together, so bubbles are preserved rather than squeezed out.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        st_data[i]    <= '0;
        st_flags[i]   <= '0;
        st_illegal[i] <= 1'b0;
        st_valid[i]   <= 1'b0;
      end
    end else if (adv) begin
      st_data[0]    <= core_result;
      st_flags[0]   <= core_flags;
      st_illegal[0] <= core_illegal;
      st_valid[0]   <= in_valid;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        st_data[i]    <= st_data[i-1];
        st_flags[i]   <= st_flags[i-1];
        st_illegal[i] <= st_illegal[i-1];
        st_valid[i]   <= st_valid[i-1];
      end
    end
  end

  assign out_valid   = st_valid[PIPE_STAGES-1];
  assign out_data    = st_data[PIPE_STAGES-1];
  assign out_flags   = st_flags[PIPE_STAGES-1];
  assign out_illegal = st_illegal[PIPE_STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed ops, backpressure, reset flush and a PIPE_STAGES latency sweep.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] f;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [7:0] in_a, in_b, out_data;
  logic [3:0] in_op, out_flags;

  logic       lv;
  logic [7:0] la, lb;
  logic [3:0] lop;
  logic       lat_ir [4];
  logic       lat_ov [4];
  logic [7:0] lat_od [4];
  logic [3:0] lat_of [4];
  logic       lat_oi [4];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .PIPE_STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .out_illegal(out_illegal)
  );

  for (genvar g = 0; g < 4; g++) begin : g_lat
    alu_pipe #(.WIDTH(8), .PIPE_STAGES(g + 1)) u_lat (
      .clk(clk), .rst(rst), .in_valid(lv), .in_ready(lat_ir[g]),
      .in_a(la), .in_b(lb), .in_op(lop), .out_valid(lat_ov[g]),
      .out_ready(1'b1), .out_data(lat_od[g]), .out_flags(lat_of[g]),
      .out_illegal(lat_oi[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic [3:0] ef, input logic ei,
                      input bit push);
    int waits = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    #1;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    if (push) exp_q.push_back('{d: ed, f: ef, ill: ei});
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops one expectation per output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          pops++;
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_flags", 32'(out_flags), 32'(e.f));
          chk("out_illegal", 32'(out_illegal), 32'(e.ill));
        end
      end
    end
  end

  initial begin
    int pops0;
    logic [7:0] snap;
    int first [4];
    logic [7:0] first_d [4];

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    lv = 1'b0; la = '0; lb = '0; lop = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, flags = {V,C,N,Z}
    send(OP_ADD,   8'hFF, 8'h01, 8'h00, 4'b0101, 1'b0, 1'b1);
    send(OP_ADD,   8'h7F, 8'h01, 8'h80, 4'b1010, 1'b0, 1'b1);
    send(OP_SUB,   8'h80, 8'h01, 8'h7F, 4'b1000, 1'b0, 1'b1);
    send(OP_SUB,   8'h01, 8'h02, 8'hFF, 4'b0110, 1'b0, 1'b1);
    send(OP_AND,   8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0, 1'b1);
    send(OP_OR,    8'h0F, 8'hF0, 8'hFF, 4'b0010, 1'b0, 1'b1);
    send(OP_XOR,   8'hAA, 8'hAA, 8'h00, 4'b0001, 1'b0, 1'b1);
    send(OP_NOT,   8'h0F, 8'h00, 8'hF0, 4'b0010, 1'b0, 1'b1);
    send(OP_SHL1,  8'h81, 8'h00, 8'h02, 4'b0100, 1'b0, 1'b1);
    send(OP_SHR1,  8'h81, 8'h00, 8'h40, 4'b0100, 1'b0, 1'b1);
    send(OP_SLL,   8'h81, 8'h09, 8'h02, 4'b0000, 1'b0, 1'b1);
    send(OP_SRL,   8'h90, 8'h03, 8'h12, 4'b0000, 1'b0, 1'b1);
    send(OP_SRA,   8'h90, 8'h03, 8'hF2, 4'b0010, 1'b0, 1'b1);
    send(OP_SLT,   8'h80, 8'h01, 8'h01, 4'b0000, 1'b0, 1'b1);
    send(OP_SLTU,  8'h80, 8'h01, 8'h00, 4'b0001, 1'b0, 1'b1);
    send(OP_PASSB, 8'h00, 8'h5A, 8'h5A, 4'b0000, 1'b0, 1'b1);
`ifdef ALU_PIPE_MUL_EN
    send(OP_MUL,   8'h10, 8'h20, 8'h00, 4'b0101, 1'b0, 1'b1);
    send(OP_MULHU, 8'h10, 8'h20, 8'h02, 4'b0000, 1'b0, 1'b1);
`else
    send(OP_MUL,   8'h10, 8'h20, 8'h00, 4'b0001, 1'b1, 1'b1);
    send(OP_MULHU, 8'h10, 8'h20, 8'h00, 4'b0001, 1'b1, 1'b1);
`endif
    idle();
    drain();

    // Backpressure: 6 back-to-back ops with a 3-cycle stall mid-stream
    pops0 = pops;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(OP_ADD, 8'(i), 8'(i), 8'(2 * i), 4'b0000, 1'b0, 1'b1);
      end
      begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (k != 0) @(negedge clk);
          out_ready = 1'b0;
          #1;
          if (k == 0) snap = out_data;
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_data_hold", 32'(out_data), 32'(snap));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle();
    drain();
    chk("bp_result_count", 32'(pops - pops0), 32'd6);

    // Reset with two ops in flight and output stalled: both must vanish
    out_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h02, 8'h03, 4'b0000, 1'b0, 1'b0);
    send(OP_SUB, 8'h05, 8'h03, 8'h02, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("inflight_stalled_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_flush_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_stale_output", 32'(out_valid), 32'd0);

    // Latency sweep over PIPE_STAGES 1..4: ADD 3+4 on one edge, expect out_valid PIPE_STAGES-1 edges later
    for (int g = 0; g < 4; g++) begin
      first[g] = -1;
      first_d[g] = '0;
    end
    @(negedge clk);
    lv = 1'b1; la = 8'd3; lb = 8'd4; lop = OP_ADD;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      #1;
      for (int g = 0; g < 4; g++) begin
        if (lat_ov[g] && first[g] < 0) begin
          first[g] = k;
          first_d[g] = lat_od[g];
        end
      end
      @(negedge clk);
      lv = 1'b0;
      @(posedge clk);
    end
    for (int g = 0; g < 4; g++) begin
      chk("latency", 32'(first[g]), 32'(g));
      chk("latency_data", 32'(first_d[g]), 32'd7);
    end

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
